// File: rtl/rename_ctrl_if.sv
// Port bundle for the rename stage: decode handshake, rename-table ports,
// dispatch handshake, commit feedback and recovery status.
interface rename_ctrl_if #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 48
);
  localparam int unsigned PW = $clog2(PHYS_REGS);
  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned CW = $clog2(PHYS_REGS - ARCH_REGS + 1);

  logic          dec_valid;
  logic          dec_ready;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic [AW-1:0] dec_rd;
  logic          dec_wr_rd;

  logic [AW-1:0] rt_arch_rs1;
  logic [AW-1:0] rt_arch_rs2;
  logic [PW-1:0] rt_phys_rs1;
  logic [PW-1:0] rt_phys_rs2;
  logic [PW-1:0] rt_phys_rd_cur;
  logic          rt_rename_en;
  logic [AW-1:0] rt_arch_rd;
  logic [PW-1:0] rt_new_phys_rd;
  logic          rt_restore_en;
  logic [AW-1:0] rt_restore_idx;

  logic          ren_valid;
  logic          ren_ready;
  logic [PW-1:0] ren_phys_rs1;
  logic [PW-1:0] ren_phys_rs2;
  logic [PW-1:0] ren_phys_rd;
  logic [PW-1:0] ren_old_phys_rd;
  logic          ren_has_rd;

  logic          commit_en;
  logic          commit_has_rd;
  logic [PW-1:0] commit_old_phys_rd;
  logic          flush;
  logic          busy;
  logic [CW-1:0] free_count;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_wr_rd,
    input  rt_phys_rs1, rt_phys_rs2, rt_phys_rd_cur,
    input  ren_ready, commit_en, commit_has_rd, commit_old_phys_rd, flush,
    output dec_ready, rt_arch_rs1, rt_arch_rs2, rt_rename_en, rt_arch_rd,
    output rt_new_phys_rd, rt_restore_en, rt_restore_idx,
    output ren_valid, ren_phys_rs1, ren_phys_rs2, ren_phys_rd, ren_old_phys_rd,
    output ren_has_rd, busy, free_count
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_wr_rd,
    output rt_phys_rs1, rt_phys_rs2, rt_phys_rd_cur,
    output ren_ready, commit_en, commit_has_rd, commit_old_phys_rd, flush,
    input  dec_ready, rt_arch_rs1, rt_arch_rs2, rt_rename_en, rt_arch_rd,
    input  rt_new_phys_rd, rt_restore_en, rt_restore_idx,
    input  ren_valid, ren_phys_rs1, ren_phys_rs2, ren_phys_rd, ren_old_phys_rd,
    input  ren_has_rd, busy, free_count
  );
endinterface

// File: rtl/rename_ctrl.sv
// Rename-stage sequencer: owns the physical free list, renames one uop per
// cycle, and walks the rename table back to committed state after a flush.
module rename_ctrl #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 48
) (
  input  logic          clk,
  input  logic          reset,
  rename_ctrl_if.slave  bus
);
  localparam int unsigned FREE_REGS = PHYS_REGS - ARCH_REGS;
  localparam int unsigned PW        = $clog2(PHYS_REGS);
  localparam int unsigned AW        = $clog2(ARCH_REGS);
  localparam int unsigned PTR_W     = $clog2(FREE_REGS);
  localparam int unsigned CNT_W     = $clog2(FREE_REGS + 1);
  localparam logic [AW-1:0] XZR     = AW'(ARCH_REGS - 1);

  typedef enum logic {RUN, RECOVER} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     fl_q [FREE_REGS];
  logic [PW-1:0]     fl_d [FREE_REGS];
  logic [PTR_W-1:0]  head_q, head_d, chead_q, chead_d, tail_q, tail_d;
  logic [CNT_W-1:0]  spec_q, spec_d, ccnt_q, ccnt_d;
  logic              ren_valid_q, ren_valid_d, ren_has_rd_q, ren_has_rd_d;
  logic [PW-1:0]     ren_p1_q, ren_p1_d, ren_p2_q, ren_p2_d;
  logic [PW-1:0]     ren_rd_q, ren_rd_d, ren_old_q, ren_old_d;

  logic needs_alloc, dec_ready_c, accept, alloc, commit_fire, restore_en_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FREE_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign needs_alloc = bus.dec_wr_rd && (bus.dec_rd != XZR);
  assign commit_fire = bus.commit_en && bus.commit_has_rd;

  // Next-state, free-list and output-register logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fl_d         = fl_q;
    head_d       = head_q;
    chead_d      = chead_q;
    tail_d       = tail_q;
    spec_d       = spec_q;
    ccnt_d       = ccnt_q;
    ren_valid_d  = ren_valid_q;
    ren_has_rd_d = ren_has_rd_q;
    ren_p1_d     = ren_p1_q;
    ren_p2_d     = ren_p2_q;
    ren_rd_d     = ren_rd_q;
    ren_old_d    = ren_old_q;
    dec_ready_c  = 1'b0;
    restore_en_c = 1'b0;

    unique case (state_q)
      RUN: begin
        dec_ready_c = !bus.flush && (!ren_valid_q || bus.ren_ready) &&
                      (!needs_alloc || spec_q != '0);
      end
      RECOVER: begin
        restore_en_c = 1'b1;
        if (idx_q == XZR) begin
          idx_d   = '0;
          state_d = RUN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    accept = bus.dec_valid && dec_ready_c;
    alloc  = accept && needs_alloc;

    if (commit_fire) begin
      fl_d[tail_q] = bus.commit_old_phys_rd;
      tail_d       = ptr_inc(tail_q);
      chead_d      = ptr_inc(chead_q);
    end
    if (alloc) head_d = ptr_inc(head_q);

    unique case ({commit_fire, alloc})
      2'b10:   spec_d = spec_q + 1'b1;
      2'b01:   spec_d = spec_q - 1'b1;
      default: spec_d = spec_q;
    endcase

    if (accept) begin
      ren_valid_d  = 1'b1;
      ren_p1_d     = bus.rt_phys_rs1;
      ren_p2_d     = bus.rt_phys_rs2;
      ren_rd_d     = needs_alloc ? fl_q[head_q] : '0;
      ren_old_d    = needs_alloc ? bus.rt_phys_rd_cur : '0;
      ren_has_rd_d = needs_alloc;
    end else if (bus.ren_ready) begin
      ren_valid_d  = 1'b0;
      ren_p1_d     = '0;
      ren_p2_d     = '0;
      ren_rd_d     = '0;
      ren_old_d    = '0;
      ren_has_rd_d = 1'b0;
    end

    // Flush rewinds speculation to the committed head, including this cycle's commit.
    if (bus.flush) begin
      state_d      = RECOVER;
      idx_d        = '0;
      head_d       = chead_d;
      spec_d       = ccnt_q;
      ren_valid_d  = 1'b0;
      ren_p1_d     = '0;
      ren_p2_d     = '0;
      ren_rd_d     = '0;
      ren_old_d    = '0;
      ren_has_rd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      idx_q        <= '0;
      for (int i = 0; i < FREE_REGS; i++) fl_q[i] <= PW'(ARCH_REGS + i);
      head_q       <= '0;
      chead_q      <= '0;
      tail_q       <= '0;
      spec_q       <= CNT_W'(FREE_REGS);
      ccnt_q       <= CNT_W'(FREE_REGS);
      ren_valid_q  <= 1'b0;
      ren_has_rd_q <= 1'b0;
      ren_p1_q     <= '0;
      ren_p2_q     <= '0;
      ren_rd_q     <= '0;
      ren_old_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fl_q         <= fl_d;
      head_q       <= head_d;
      chead_q      <= chead_d;
      tail_q       <= tail_d;
      spec_q       <= spec_d;
      ccnt_q       <= ccnt_d;
      ren_valid_q  <= ren_valid_d;
      ren_has_rd_q <= ren_has_rd_d;
      ren_p1_q     <= ren_p1_d;
      ren_p2_q     <= ren_p2_d;
      ren_rd_q     <= ren_rd_d;
      ren_old_q    <= ren_old_d;
    end
  end

  assign bus.dec_ready       = dec_ready_c;
  assign bus.rt_arch_rs1     = bus.dec_rs1;
  assign bus.rt_arch_rs2     = bus.dec_rs2;
  assign bus.rt_rename_en    = alloc;
  assign bus.rt_arch_rd      = bus.dec_rd;
  assign bus.rt_new_phys_rd  = fl_q[head_q];
  assign bus.rt_restore_en   = restore_en_c;
  assign bus.rt_restore_idx  = idx_q;
  assign bus.ren_valid       = ren_valid_q;
  assign bus.ren_phys_rs1    = ren_p1_q;
  assign bus.ren_phys_rs2    = ren_p2_q;
  assign bus.ren_phys_rd     = ren_rd_q;
  assign bus.ren_old_phys_rd = ren_old_q;
  assign bus.ren_has_rd      = ren_has_rd_q;
  assign bus.busy            = (state_q == RECOVER);
  assign bus.free_count      = spec_q;

  // A retirement that frees a tag while the free list is already full is illegal.
  spec_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(commit_fire && !alloc && !bus.flush && spec_q == CNT_W'(FREE_REGS)));
endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl with a free-list model and a uop scoreboard.
module tb_rename_ctrl;
  logic clk = 1'b0;
  logic reset;

  rename_ctrl_if bus ();
  rename_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] p1;
    logic [5:0] p2;
    logic [5:0] rd;
    logic [5:0] old;
    logic       has_rd;
  } uop_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  uop_t sb [$];

  logic [5:0] m_fl [16];
  int m_head, m_chead, m_tail, m_cnt, m_state, m_idx;
  logic m_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_fl[i] = 6'(32 + i);
    m_head = 0; m_chead = 0; m_tail = 0; m_cnt = 16;
    m_state = 0; m_idx = 0; m_rv = 1'b0;
    sb.delete();
  endtask

  task automatic dec(input logic v, input logic [4:0] rd, input logic wr);
    bus.dec_valid      = v;
    bus.dec_rd         = rd;
    bus.dec_wr_rd      = wr;
    bus.dec_rs1        = 5'($urandom_range(0, 31));
    bus.dec_rs2        = 5'($urandom_range(0, 31));
    bus.rt_phys_rs1    = 6'($urandom_range(0, 47));
    bus.rt_phys_rs2    = 6'($urandom_range(0, 47));
    bus.rt_phys_rd_cur = 6'($urandom_range(0, 47));
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check free_count.
  task automatic tick();
    logic na, er, acc;
    uop_t u;
    #2;
    na  = bus.dec_wr_rd && (bus.dec_rd != 5'd31);
    er  = (m_state == 0) && !bus.flush && (!m_rv || bus.ren_ready) && (!na || m_cnt != 0);
    acc = bus.dec_valid && er;
    check("dec_ready", 32'(bus.dec_ready), 32'(er));
    check("busy", 32'(bus.busy), 32'(m_state));
    check("ren_valid", 32'(bus.ren_valid), 32'(m_rv));
    check("rename_en", 32'(bus.rt_rename_en), 32'(acc && na));
    if (m_state == 1) begin
      check("restore_en", 32'(bus.rt_restore_en), 32'(1));
      check("restore_idx", 32'(bus.rt_restore_idx), 32'(m_idx));
    end
    if (acc && na) check("new_phys_rd", 32'(bus.rt_new_phys_rd), 32'(m_fl[m_head]));
    if (m_rv && bus.ren_ready) begin
      if (sb.size() != 0) u = sb.pop_front();
      else u = '1;
      check("ren_uop", 32'({bus.ren_phys_rs1, bus.ren_phys_rs2, bus.ren_phys_rd,
                            bus.ren_old_phys_rd, bus.ren_has_rd}), 32'(u));
    end
    if (acc) begin
      u = '{p1: bus.rt_phys_rs1, p2: bus.rt_phys_rs2,
            rd: na ? m_fl[m_head] : 6'd0, old: na ? bus.rt_phys_rd_cur : 6'd0, has_rd: na};
      sb.push_back(u);
      if (na) begin m_head = (m_head + 1) % 16; m_cnt--; end
      m_rv = 1'b1;
    end else if (bus.ren_ready) begin
      m_rv = 1'b0;
    end
    if (bus.commit_en && bus.commit_has_rd) begin
      m_fl[m_tail] = bus.commit_old_phys_rd;
      m_tail  = (m_tail + 1) % 16;
      m_chead = (m_chead + 1) % 16;
      m_cnt++;
    end
    if (m_state == 1) begin
      if (m_idx == 31) begin m_state = 0; m_idx = 0; end
      else m_idx++;
    end
    if (bus.flush) begin
      m_state = 1; m_idx = 0; m_head = m_chead; m_cnt = 16; m_rv = 1'b0;
      sb.delete();
    end
    @(posedge clk);
    #1;
    check("free_count", 32'(bus.free_count), 32'(m_cnt));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic count_walk(input string tag);
    int n = 0;
    while (bus.busy && n < 40) begin
      #1;
      check({tag, "_idx"}, 32'(bus.rt_restore_idx), 32'(n));
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(32));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    dec(1'b0, 5'd0, 1'b0);
    bus.ren_ready = 1'b0;
    bus.commit_en = 1'b0;
    bus.commit_has_rd = 1'b0;
    bus.commit_old_phys_rd = 6'd0;
    bus.flush = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ren_valid", 32'(bus.ren_valid), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_free_count", 32'(bus.free_count), 32'(16));
    check("rst_ren_phys_rd", 32'(bus.ren_phys_rd), 32'(0));
    reset = 1'b0;

    // Drain the whole free list in allocation order.
    bus.ren_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dec(1'b1, 5'(i + 1), 1'b1);
      #1;
      check("alloc_order", 32'(bus.rt_new_phys_rd), 32'(32 + i));
      tick();
    end
    check("empty_free_count", 32'(bus.free_count), 32'(0));
    dec(1'b1, 5'd17, 1'b1);
    #1;
    check("empty_ready", 32'(bus.dec_ready), 32'(0));
    tick();
    dec(1'b1, 5'd31, 1'b1);
    #1;
    check("xzr_ready", 32'(bus.dec_ready), 32'(1));
    tick();
    dec(1'b0, 5'd0, 1'b0);
    check("xzr_valid", 32'(bus.ren_valid), 32'(1));
    check("xzr_has_rd", 32'(bus.ren_has_rd), 32'(0));
    tick();

    // Dispatch backpressure holds the output register.
    pulse_reset();
    bus.ren_ready = 1'b0;
    dec(1'b1, 5'd1, 1'b1);
    tick();
    dec(1'b1, 5'd2, 1'b1);
    repeat (3) begin
      #1;
      check("hold_phys_rd", 32'(bus.ren_phys_rd), 32'(32));
      tick();
    end
    bus.ren_ready = 1'b1;
    tick();
    dec(1'b0, 5'd0, 1'b0);
    check("release_phys_rd", 32'(bus.ren_phys_rd), 32'(33));
    tick();

    // Commit concurrent with allocation; freed tag lands in entry 0.
    pulse_reset();
    dec(1'b1, 5'd1, 1'b1); tick();
    dec(1'b1, 5'd2, 1'b1); tick();
    dec(1'b1, 5'd3, 1'b1);
    bus.commit_en = 1'b1; bus.commit_has_rd = 1'b1; bus.commit_old_phys_rd = 6'd5;
    tick();
    bus.commit_en = 1'b0;
    check("commit_alloc_count", 32'(bus.free_count), 32'(14));
    for (int i = 0; i < 13; i++) begin
      dec(1'b1, 5'(4 + i), 1'b1);
      tick();
    end
    dec(1'b1, 5'd20, 1'b1);
    #1;
    check("wrapped_entry0", 32'(bus.rt_new_phys_rd), 32'(5));
    tick();
    dec(1'b0, 5'd0, 1'b0);
    tick();

    // Flush after partial commit: full walk, then resume at committed head.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      dec(1'b1, 5'(i + 1), 1'b1);
      tick();
    end
    dec(1'b0, 5'd0, 1'b0);
    bus.commit_en = 1'b1; bus.commit_old_phys_rd = 6'd3;
    tick();
    bus.commit_en = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    count_walk("walk");
    check("post_walk_count", 32'(bus.free_count), 32'(16));
    dec(1'b1, 5'd5, 1'b1);
    #1;
    check("post_flush_alloc", 32'(bus.rt_new_phys_rd), 32'(33));
    tick();
    dec(1'b0, 5'd0, 1'b0);

    // Re-flush mid-walk with a concurrent commit restarts the walk.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (10) tick();
    check("reflush_at_idx", 32'(bus.rt_restore_idx), 32'(10));
    bus.flush = 1'b1;
    bus.commit_en = 1'b1; bus.commit_old_phys_rd = 6'd7;
    tick();
    bus.flush = 1'b0;
    bus.commit_en = 1'b0;
    count_walk("rewalk");
    dec(1'b1, 5'd6, 1'b1);
    #1;
    check("rewalk_alloc", 32'(bus.rt_new_phys_rd), 32'(34));
    tick();
    dec(1'b0, 5'd0, 1'b0);
    tick();

    // Asynchronous reset in the middle of a walk.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (20) tick();
    check("reset_at_idx", 32'(bus.rt_restore_idx), 32'(20));
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 32'(bus.busy), 32'(0));
    check("mid_reset_count", 32'(bus.free_count), 32'(16));
    check("mid_reset_idx", 32'(bus.rt_restore_idx), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    dec(1'b1, 5'd7, 1'b1);
    #1;
    check("post_reset_alloc", 32'(bus.rt_new_phys_rd), 32'(32));
    tick();
    dec(1'b0, 5'd0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
